// File: rtl/mem_access.sv
// MEM pipeline stage: runs loads/stores over a req/ack bus with wait states,
// formats big-endian byte/half/word data and holds its result while MEM is stalled.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrn_i,
    input  logic [4:0]  wrAddr_i,
    input  logic [31:0] wrData_i,
    input  logic        wrn_HILO_i,
    input  logic [31:0] wrData_HI_i,
    input  logic [31:0] wrData_LO_i,
    input  logic [3:0]  memop_i,
    input  logic [31:0] memAddr_i,
    input  logic [31:0] memData_i,
    input  logic [5:0]  stall,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic        wrn_o,
    output logic [4:0]  wrAddr_o,
    output logic [31:0] wrData_o,
    output logic        wrn_HILO_o,
    output logic [31:0] wrData_HI_o,
    output logic [31:0] wrData_LO_o
);
    localparam logic [1:0] S_IDLE = 2'd0, S_BUS = 2'd1, S_DONE = 2'd2, S_DRAIN = 2'd3;
    localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                           OP_LW = 4'd5, OP_SB = 4'd8, OP_SH = 4'd9, OP_SW = 4'd10;

    logic [1:0]  r_state;
    logic [3:0]  r_memop;
    logic [1:0]  r_off;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_sel;
    logic [31:0] r_wdata;
    logic        r_wrn;
    logic [4:0]  r_wr_addr;
    logic [31:0] r_wr_data;
    logic        r_wrn_hilo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_in_load, w_in_store, w_in_misalign;
    logic [3:0]  w_in_sel;
    logic [31:0] w_in_wdata;
    logic        w_go, w_ack_cap;
    logic [3:0]  w_op;
    logic [1:0]  w_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_live_data;
    logic        w_unused;

    assign w_unused = ^{stall[5], stall[3:0]};

    always_comb begin
        w_in_load     = 1'b0;
        w_in_store    = 1'b0;
        w_in_misalign = 1'b0;
        w_in_sel      = 4'b0000;
        w_in_wdata    = 32'h0;
        case (memop_i)
            OP_LB, OP_LBU: begin
                w_in_load = 1'b1;
                w_in_sel  = 4'b1000 >> memAddr_i[1:0];
            end
            OP_LH, OP_LHU: begin
                w_in_load     = 1'b1;
                w_in_misalign = memAddr_i[0];
                w_in_sel      = memAddr_i[1] ? 4'b0011 : 4'b1100;
            end
            OP_LW: begin
                w_in_load     = 1'b1;
                w_in_misalign = |memAddr_i[1:0];
                w_in_sel      = 4'b1111;
            end
            OP_SB: begin
                w_in_store = 1'b1;
                w_in_sel   = 4'b1000 >> memAddr_i[1:0];
                w_in_wdata = {4{memData_i[7:0]}};
            end
            OP_SH: begin
                w_in_store    = 1'b1;
                w_in_misalign = memAddr_i[0];
                w_in_sel      = memAddr_i[1] ? 4'b0011 : 4'b1100;
                w_in_wdata    = {2{memData_i[15:0]}};
            end
            OP_SW: begin
                w_in_store    = 1'b1;
                w_in_misalign = |memAddr_i[1:0];
                w_in_sel      = 4'b1111;
                w_in_wdata    = memData_i;
            end
            default: ;
        endcase
    end

    assign w_go      = (w_in_load | w_in_store) & ~w_in_misalign & ~flush_i;
    assign w_ack_cap = mem_ack_i & ~flush_i & ((r_state == S_IDLE & w_go) | (r_state == S_BUS));

    // Once the access has left IDLE the latched op decides formatting, not the live input.
    assign w_op  = (r_state == S_IDLE) ? memop_i : r_memop;
    assign w_off = (r_state == S_IDLE) ? memAddr_i[1:0] : r_off;

    always_comb begin
        case (w_off)
            2'd0:    w_byte = mem_rdata_i[31:24];
            2'd1:    w_byte = mem_rdata_i[23:16];
            2'd2:    w_byte = mem_rdata_i[15:8];
            default: w_byte = mem_rdata_i[7:0];
        endcase
        w_half = w_off[1] ? mem_rdata_i[15:0] : mem_rdata_i[31:16];
        case (w_op)
            OP_LB:   w_live_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_live_data = {24'h0, w_byte};
            OP_LH:   w_live_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_live_data = {16'h0, w_half};
            OP_LW:   w_live_data = mem_rdata_i;
            default: w_live_data = wrData_i;
        endcase
    end

    // Reset also gates the pass-through paths so every output reads 0 while rst is low.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'h0;
        mem_sel_o   = 4'b0000;
        mem_wdata_o = 32'h0;
        stallreq_o  = 1'b0;
        misalign_o  = 1'b0;
        wrn_o       = 1'b0;
        wrAddr_o    = 5'd0;
        wrData_o    = 32'h0;
        wrn_HILO_o  = 1'b0;
        wrData_HI_o = 32'h0;
        wrData_LO_o = 32'h0;
        if (rst) begin
            wrAddr_o    = wrAddr_i;
            wrData_o    = w_live_data;
            wrData_HI_o = wrData_HI_i;
            wrData_LO_o = wrData_LO_i;
            case (r_state)
                S_IDLE: begin
                    mem_req_o  = w_go;
                    if (w_go) begin
                        mem_we_o    = w_in_store;
                        mem_addr_o  = {memAddr_i[31:2], 2'b00};
                        mem_sel_o   = w_in_sel;
                        mem_wdata_o = w_in_wdata;
                    end
                    misalign_o = w_in_misalign & ~flush_i;
                    stallreq_o = w_go & ~mem_ack_i;
                    wrn_o      = wrn_i & ~flush_i & ~w_in_misalign & ~(w_go & ~mem_ack_i);
                    wrn_HILO_o = wrn_HILO_i & ~flush_i & ~(w_go & ~mem_ack_i);
                end
                S_BUS: begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = r_we;
                    mem_addr_o  = r_addr;
                    mem_sel_o   = r_sel;
                    mem_wdata_o = r_wdata;
                    stallreq_o  = ~mem_ack_i;
                    wrn_o       = wrn_i & mem_ack_i & ~flush_i;
                    wrn_HILO_o  = wrn_HILO_i & mem_ack_i & ~flush_i;
                end
                S_DONE: begin
                    wrn_o       = r_wrn & ~flush_i;
                    wrAddr_o    = r_wr_addr;
                    wrData_o    = r_wr_data;
                    wrn_HILO_o  = r_wrn_hilo & ~flush_i;
                    wrData_HI_o = r_hi;
                    wrData_LO_o = r_lo;
                end
                default: begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = r_we;
                    mem_addr_o  = r_addr;
                    mem_sel_o   = r_sel;
                    mem_wdata_o = r_wdata;
                    stallreq_o  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_memop    <= 4'd0;
            r_off      <= 2'd0;
            r_we       <= 1'b0;
            r_addr     <= 32'h0;
            r_sel      <= 4'b0000;
            r_wdata    <= 32'h0;
            r_wrn      <= 1'b0;
            r_wr_addr  <= 5'd0;
            r_wr_data  <= 32'h0;
            r_wrn_hilo <= 1'b0;
            r_hi       <= 32'h0;
            r_lo       <= 32'h0;
        end else begin
            if (w_ack_cap) begin
                r_wrn      <= wrn_i;
                r_wr_addr  <= wrAddr_i;
                r_wr_data  <= w_live_data;
                r_wrn_hilo <= wrn_HILO_i;
                r_hi       <= wrData_HI_i;
                r_lo       <= wrData_LO_i;
            end
            case (r_state)
                S_IDLE: if (w_go) begin
                    r_memop <= memop_i;
                    r_off   <= memAddr_i[1:0];
                    r_we    <= w_in_store;
                    r_addr  <= {memAddr_i[31:2], 2'b00};
                    r_sel   <= w_in_sel;
                    r_wdata <= w_in_wdata;
                    if (!mem_ack_i)   r_state <= S_BUS;
                    else if (stall[4]) r_state <= S_DONE;
                end
                S_BUS: begin
                    if (mem_ack_i)    r_state <= (!flush_i && stall[4]) ? S_DONE : S_IDLE;
                    else if (flush_i) r_state <= S_DRAIN;
                end
                S_DONE:  if (!stall[4] || flush_i) r_state <= S_IDLE;
                default: if (mem_ack_i) r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a load-result scoreboard plus immediate-assertion
// checks on bus fields, stall behaviour, misalignment, flush/drain and reset.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        rst;
    logic        wrn_i, wrn_HILO_i, flush_i, mem_ack_i;
    logic [4:0]  wrAddr_i;
    logic [31:0] wrData_i, wrData_HI_i, wrData_LO_i, memAddr_i, memData_i, mem_rdata_i;
    logic [3:0]  memop_i;
    logic [5:0]  stall;
    logic        mem_req_o, mem_we_o, stallreq_o, misalign_o, wrn_o, wrn_HILO_o;
    logic [31:0] mem_addr_o, mem_wdata_o, wrData_o, wrData_HI_o, wrData_LO_o;
    logic [3:0]  mem_sel_o;
    logic [4:0]  wrAddr_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst),
        .wrn_i(wrn_i), .wrAddr_i(wrAddr_i), .wrData_i(wrData_i),
        .wrn_HILO_i(wrn_HILO_i), .wrData_HI_i(wrData_HI_i), .wrData_LO_i(wrData_LO_i),
        .memop_i(memop_i), .memAddr_i(memAddr_i), .memData_i(memData_i),
        .stall(stall), .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .stallreq_o(stallreq_o), .misalign_o(misalign_o),
        .wrn_o(wrn_o), .wrAddr_o(wrAddr_o), .wrData_o(wrData_o),
        .wrn_HILO_o(wrn_HILO_o), .wrData_HI_o(wrData_HI_o), .wrData_LO_o(wrData_LO_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        memop_i = 4'd0; memAddr_i = 32'h0; memData_i = 32'h0;
        wrn_i = 1'b0; wrn_HILO_i = 1'b0; wrAddr_i = 5'd0; wrData_i = 32'h0;
        stall = 6'd0; flush_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] want;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, wrData_o);
        end else begin
            want = exp_q.pop_front();
            check(tag, wrData_o, want);
        end
    endtask

    // One memory transaction: waits cycles without ack, then an ack cycle.
    task automatic mem_txn(input string name, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] sdata, input int waits, input logic [31:0] rdata,
                           input logic [31:0] exp_data, input logic [3:0] exp_sel,
                           input logic exp_we, input logic [31:0] exp_wdata);
        int hi_cnt = 0;
        memop_i = op; memAddr_i = addr; memData_i = sdata;
        wrn_i = (op < 4'd8); wrAddr_i = 5'd7; wrData_i = 32'h0BAD_0000 ^ addr;
        stall = 6'd0; flush_i = 1'b0;
        exp_q.push_back(exp_data);
        for (int c = 0; c < waits; c++) begin
            mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
            @(negedge clk);
            if (stallreq_o) hi_cnt++;
            check({name, " req_wait"}, 32'(mem_req_o), 32'd1);
            check({name, " sel_wait"}, 32'(mem_sel_o), 32'(exp_sel));
            check({name, " wrn_wait"}, 32'(wrn_o), 32'd0);
            step();
        end
        mem_ack_i = 1'b1; mem_rdata_i = rdata;
        @(negedge clk);
        check({name, " req"}, 32'(mem_req_o), 32'd1);
        check({name, " addr"}, mem_addr_o, {addr[31:2], 2'b00});
        check({name, " sel"}, 32'(mem_sel_o), 32'(exp_sel));
        check({name, " we"}, 32'(mem_we_o), 32'(exp_we));
        check({name, " wdata"}, mem_wdata_o, exp_wdata);
        check({name, " stallreq_ack"}, 32'(stallreq_o), 32'd0);
        check({name, " misalign"}, 32'(misalign_o), 32'd0);
        check({name, " wrn"}, 32'(wrn_o), 32'(op < 4'd8));
        pop_check({name, " wrData"});
        step();
        check({name, " stall_cycles"}, 32'(hi_cnt), 32'(waits));
        $display("txn %s op=%0d addr=%h waits=%0d wrData=%h", name, op, addr, waits, exp_data);
        idle_in();
    endtask

    initial begin
        idle_in();
        rst = 1'b0;
        memop_i = 4'd5; memAddr_i = 32'h100; wrn_i = 1'b1; wrData_i = 32'h55;
        #12;
        check("rst req", 32'(mem_req_o), 32'd0);
        check("rst addr", mem_addr_o, 32'h0);
        check("rst wrn", 32'(wrn_o), 32'd0);
        check("rst wrData", wrData_o, 32'h0);
        check("rst stallreq", 32'(stallreq_o), 32'd0);
        $display("txn reset");
        idle_in();
        @(negedge clk);
        rst = 1'b1;
        step();

        // Pass-through for non-memory and unknown codes.
        wrn_i = 1'b1; wrAddr_i = 5'h1F; wrData_i = 32'hCAFE_F00D;
        wrn_HILO_i = 1'b1; wrData_HI_i = 32'h1234_5678; wrData_LO_i = 32'h9ABC_DEF0;
        @(negedge clk);
        check("none wrn", 32'(wrn_o), 32'd1);
        check("none wrAddr", 32'(wrAddr_o), 32'h1F);
        check("none wrData", wrData_o, 32'hCAFE_F00D);
        check("none hilo", 32'(wrn_HILO_o), 32'd1);
        check("none hi", wrData_HI_o, 32'h1234_5678);
        check("none lo", wrData_LO_o, 32'h9ABC_DEF0);
        check("none req", 32'(mem_req_o), 32'd0);
        step();
        memop_i = 4'd7; memAddr_i = 32'h100;
        @(negedge clk);
        check("op7 req", 32'(mem_req_o), 32'd0);
        check("op7 wrData", wrData_o, 32'hCAFE_F00D);
        $display("txn passthrough");
        step();
        memop_i = 4'd5; flush_i = 1'b1;
        @(negedge clk);
        check("flush_idle req", 32'(mem_req_o), 32'd0);
        check("flush_idle wrn", 32'(wrn_o), 32'd0);
        check("flush_idle hilo", 32'(wrn_HILO_o), 32'd0);
        check("flush_idle stallreq", 32'(stallreq_o), 32'd0);
        $display("txn flush_idle");
        step();
        idle_in();

        mem_txn("LW",  4'd5, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0);
        mem_txn("LB",  4'd1, 32'h103, 32'h0, 2, 32'h0000_00F0, 32'hFFFF_FFF0, 4'b0001, 1'b0, 32'h0);
        mem_txn("LBU", 4'd2, 32'h103, 32'h0, 2, 32'h0000_00F0, 32'h0000_00F0, 4'b0001, 1'b0, 32'h0);
        mem_txn("LB0", 4'd1, 32'h0F0, 32'h0, 1, 32'h7F80_0000, 32'h0000_007F, 4'b1000, 1'b0, 32'h0);
        mem_txn("LHU", 4'd4, 32'h202, 32'h0, 1, 32'h1234_8765, 32'h0000_8765, 4'b0011, 1'b0, 32'h0);
        mem_txn("SH",  4'd9, 32'h202, 32'h1234_ABCD, 1, 32'h0, 32'h0BAD_0202, 4'b0011, 1'b1, 32'hABCD_ABCD);
        mem_txn("SB",  4'd8, 32'h101, 32'h0000_00CD, 0, 32'h0, 32'h0BAD_0101, 4'b0100, 1'b1, 32'hCDCD_CDCD);
        mem_txn("SW",  4'd10, 32'h204, 32'h0102_0304, 3, 32'h0, 32'h0BAD_0204, 4'b1111, 1'b1, 32'h0102_0304);

        // Misaligned accesses never reach the bus.
        memop_i = 4'd5; memAddr_i = 32'h101; wrn_i = 1'b1;
        @(negedge clk);
        check("misLW req", 32'(mem_req_o), 32'd0);
        check("misLW flag", 32'(misalign_o), 32'd1);
        check("misLW wrn", 32'(wrn_o), 32'd0);
        check("misLW stallreq", 32'(stallreq_o), 32'd0);
        step();
        memop_i = 4'd9; memAddr_i = 32'h203; wrn_i = 1'b0;
        @(negedge clk);
        check("misSH req", 32'(mem_req_o), 32'd0);
        check("misSH flag", 32'(misalign_o), 32'd1);
        $display("txn misaligned");
        step();
        idle_in();

        // LH acked while MEM is held: result must come from the capture register.
        memop_i = 4'd3; memAddr_i = 32'h200; wrn_i = 1'b1; wrData_i = 32'h1111;
        stall = 6'b010000; mem_ack_i = 1'b1; mem_rdata_i = 32'h8001_5A5A;
        exp_q.push_back(32'hFFFF_8001);
        @(negedge clk);
        pop_check("LHhold ack wrData");
        step();
        mem_ack_i = 1'b0; mem_rdata_i = 32'h7777_7777;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("LHhold done wrData", wrData_o, 32'hFFFF_8001);
            check("LHhold done req", 32'(mem_req_o), 32'd0);
            check("LHhold done stallreq", 32'(stallreq_o), 32'd0);
            check("LHhold done wrn", 32'(wrn_o), 32'd1);
            step();
        end
        stall = 6'd0;
        @(negedge clk);
        check("LHhold release wrData", wrData_o, 32'hFFFF_8001);
        step();
        memop_i = 4'd0; wrData_i = 32'h77;
        @(negedge clk);
        check("LHhold idle wrData", wrData_o, 32'h77);
        check("LHhold idle req", 32'(mem_req_o), 32'd0);
        $display("txn LH_hold wrData=ffff8001");
        step();
        idle_in();

        // Flush while BUS: drain the outstanding access, discard its data.
        memop_i = 4'd5; memAddr_i = 32'h300; wrn_i = 1'b1;
        @(negedge clk);
        check("flush start stallreq", 32'(stallreq_o), 32'd1);
        step();
        flush_i = 1'b1;
        @(negedge clk);
        check("flush bus stallreq", 32'(stallreq_o), 32'd1);
        check("flush bus wrn", 32'(wrn_o), 32'd0);
        step();
        idle_in();
        wrn_i = 1'b1; wrData_i = 32'h99;
        @(negedge clk);
        check("drain req", 32'(mem_req_o), 32'd1);
        check("drain addr", mem_addr_o, 32'h300);
        check("drain stallreq", 32'(stallreq_o), 32'd1);
        check("drain wrn", 32'(wrn_o), 32'd0);
        step();
        mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk);
        check("drain ack stallreq", 32'(stallreq_o), 32'd1);
        check("drain ack wrn", 32'(wrn_o), 32'd0);
        step();
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("drain idle stallreq", 32'(stallreq_o), 32'd0);
        check("drain idle wrn", 32'(wrn_o), 32'd1);
        check("drain idle req", 32'(mem_req_o), 32'd0);
        $display("txn flush_drain");
        step();
        idle_in();

        // Asynchronous reset in the middle of a bus access.
        memop_i = 4'd5; memAddr_i = 32'h400; wrn_i = 1'b1; wrData_i = 32'h44;
        step();
        @(negedge clk);
        check("rstbus pre req", 32'(mem_req_o), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("rstbus req", 32'(mem_req_o), 32'd0);
        check("rstbus addr", mem_addr_o, 32'h0);
        check("rstbus stallreq", 32'(stallreq_o), 32'd0);
        check("rstbus wrn", 32'(wrn_o), 32'd0);
        check("rstbus wrData", wrData_o, 32'h0);
        $display("txn reset_mid_bus");
        idle_in();
        @(negedge clk);
        rst = 1'b1;
        step();
        mem_txn("LWpost", 4'd5, 32'h500, 32'h0, 0, 32'h0A0B_0C0D, 32'h0A0B_0C0D, 4'b1111, 1'b0, 32'h0);

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM pipeline stage. Sits between the EX/MEM pipeline register and MEM_WB.
- Runs loads and stores on a req/ack data-memory bus, which may insert wait states.
- Extracts and extends byte, half and word data, formats store data and byte selects, and detects misalignment.
- Raises a stall request while a bus access is outstanding. Holds its result until the pipeline advances.

Parameters:
- none (address and data are fixed at 32 bits, register address at 5 bits)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- wrn_i  in  1  GPR write enable from EX/MEM
- wrAddr_i  in  5  GPR destination
- wrData_i  in  32  ALU result, used for non-load ops
- wrn_HILO_i  in  1  HI/LO write enable
- wrData_HI_i  in  32  HI data
- wrData_LO_i  in  32  LO data
- memop_i  in  4  memory op code (see Behaviour)
- memAddr_i  in  32  effective address
- memData_i  in  32  store source register value
- stall  in  6  pipeline stall vector; stall[4] = MEM stage held
- flush_i  in  1  discard the current op
- mem_req_o  out  1  bus request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  32  word address, {memAddr_i[31:2],2'b00}
- mem_sel_o  out  4  byte lane selects
- mem_wdata_o  out  32  store data, replicated across lanes
- mem_rdata_i  in  32  read data, valid with ack
- mem_ack_i  in  1  transfer complete
- stallreq_o  out  1  stall request to the controller
- misalign_o  out  1  misaligned access flag
- wrn_o, wrAddr_o, wrData_o, wrn_HILO_o, wrData_HI_o, wrData_LO_o  out  1/5/32/1/32/32  to MEM_WB

Behaviour:
- memop encodings:
  - 0 none; 1 LB; 2 LBU; 3 LH; 4 LHU; 5 LW; 8 SB; 9 SH; 10 SW.
  - Any other code is treated as none.
- Big-endian lanes:
  - Byte offset 0 maps to bits 31:24 and sel 1000; offset 3 maps to bits 7:0 and sel 0001.
  - A half at offset 0 uses sel 1100; at offset 2, sel 0011. A word uses sel 1111.
  - SB drives mem_wdata_o = {4{memData_i[7:0]}}; SH drives {2{memData_i[15:0]}}.
- Misaligned access:
  - Cases: LH, LHU or SH with addr[0]=1; LW or SW with addr[1:0]!=0.
  - Response: no bus request; misalign_o=1 (combinational); wrn_o=0; no stall.
- State machine, states IDLE, BUS, DONE, DRAIN:
  - IDLE, aligned memory op, no flush: drive mem_req_o=1 and the bus fields combinationally from the inputs.
    - ack in the same cycle: capture the data. Go to DONE if stall[4]=1, else stay IDLE.
    - no ack: go to BUS.
  - BUS: hold mem_req_o=1 and stable bus fields.
    - On ack, capture the data and take the same DONE/IDLE choice as above.
    - flush_i=1 without ack: go to DRAIN.
  - DONE: mem_req_o=0; outputs come from the captured register. Go to IDLE on the first cycle with stall[4]=0, or on flush_i.
  - DRAIN: hold the request until ack; discard the data; go to IDLE. stallreq_o=1 throughout, and outputs are suppressed (wrn_o=0, wrn_HILO_o=0).
- stallreq_o = (aligned mem op AND state in {IDLE,BUS} AND !mem_ack_i) OR state==DRAIN.
- Load result:
  - In the ack cycle, wrData_o is taken from mem_rdata_i; in DONE, from the captured register.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Stores keep wrn_o = wrn_i; the team's decode sets wrn_i=0 for stores.
- Non-memory ops: all to-MEM_WB outputs pass through combinationally, and nothing is registered.
- flush_i in IDLE forces mem_req_o=0 and all write enables to 0.
- Reset (rst=0, asynchronous):
  - state=IDLE; captured data = 0.
  - mem_req_o=0, mem_we_o=0, mem_sel_o=0, mem_addr_o=0, mem_wdata_o=0.
  - stallreq_o=0, misalign_o=0, wrn_o=0, wrn_HILO_o=0; all data outputs 0.
  - Reset during BUS abandons the access immediately.

Test Plan:
- LW addr 0x100, ack in the same cycle with rdata 0xDEADBEEF:
  - mem_sel_o=1111, no stallreq.
  - wrData_o=0xDEADBEEF.
  - State returns to IDLE.
- LB addr 0x103, ack after 2 wait cycles with rdata 0x000000F0:
  - stallreq_o high for 2 cycles; sel=0001.
  - wrData_o=0xFFFFFFF0.
  - LBU under the same stimulus gives 0x000000F0.
- SH addr 0x202, memData_i=0x1234ABCD, ack 1 cycle later:
  - mem_we_o=1, sel=0011, mem_wdata_o=0xABCDABCD.
- LW addr 0x101:
  - mem_req_o never asserts; misalign_o=1; wrn_o=0; stallreq_o=0.
- LH addr 0x200 with rdata 0x8001xxxx, ack while stall[4]=1 held for 3 cycles:
  - State goes to DONE.
  - wrData_o holds 0xFFFF8001 throughout.
  - State goes to IDLE when stall[4]=0.
- flush_i in BUS, ack 2 cycles later:
  - State goes to DRAIN; stallreq_o=1 until ack.
  - wrn_o=0, then IDLE.
- rst pulled low mid-BUS: all outputs go to 0 asynchronously.
